wb_arbiter: RTL and testbench

- Writer-side front end of the 32x32 register file. Merges single-cycle ALU results and variable-latency load results onto the regfile's single write port.
- Buffers load results in a small FIFO.
- Keeps a per-register scoreboard of outstanding loads, so decode can stall on RAW hazards.
- Sits between the EX/MEM stages and the regfile write port (regs_wr_en / rd_addr / rd_data).

---
 rtl/wb_arbiter.sv | 153 +++++++++++++++
 tb/tb_wb_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Write-back arbiter for the 32x32 register file: merges ALU results and buffered
// load results onto the single write port and tracks outstanding loads per register.
module wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2,
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int NREG      = 2 ** ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              alu_valid_i,
    input  logic [ADDR_W-1:0] alu_rd_i,
    input  logic [DATA_W-1:0] alu_data_i,
    input  logic              ld_issue_i,
    input  logic [ADDR_W-1:0] ld_issue_rd_i,
    input  logic              ld_valid_i,
    input  logic [ADDR_W-1:0] ld_rd_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic              ld_ready_o,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    output logic              rs1_busy_o,
    output logic              rs2_busy_o,
    output logic              regs_wr_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [CNT_W-1:0]  fifo_count_o,
    output logic              err_o
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

    logic [ADDR_W-1:0] fifo_rd_q   [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_rd_d   [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              err_q, err_d;

    logic              push_s, pop_s;
    logic [ADDR_W-1:0] head_rd_s;
    logic [DATA_W-1:0] head_data_s;
    logic              issue_err_s, stray_err_s;

    // Readiness depends on the current count only, so a same-cycle pop never frees a slot.
    always_comb begin
        ld_ready_o  = !rst_i && (count_q != FULL);
        push_s      = ld_valid_i && ld_ready_o;
        pop_s       = !alu_valid_i && (count_q != {CNT_W{1'b0}});
        head_rd_s   = fifo_rd_q[rd_ptr_q];
        head_data_s = fifo_data_q[rd_ptr_q];
        // Re-issuing a register whose load retires at this very edge is legal.
        issue_err_s = ld_issue_i && busy_q[ld_issue_rd_i]
                      && !(pop_s && (head_rd_s == ld_issue_rd_i));
        stray_err_s = push_s && (ld_rd_i != {ADDR_W{1'b0}}) && !busy_q[ld_rd_i]
                      && !(ld_issue_i && (ld_issue_rd_i == ld_rd_i));
    end

    // Next-state: write-port selection, FIFO update, scoreboard and error flag.
    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        busy_d      = busy_q;
        wr_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        rd_data_d   = rd_data_q;
        err_d       = err_q | issue_err_s | stray_err_s;

        if (alu_valid_i) begin
            wr_en_d   = (alu_rd_i != {ADDR_W{1'b0}});
            rd_addr_d = alu_rd_i;
            rd_data_d = alu_data_i;
        end else if (pop_s) begin
            wr_en_d   = (head_rd_s != {ADDR_W{1'b0}});
            rd_addr_d = head_rd_s;
            rd_data_d = head_data_s;
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            busy_d[head_rd_s] = 1'b0;
        end else begin
            wr_en_d = 1'b0;
        end

        if (push_s) begin
            fifo_rd_d[wr_ptr_q]   = ld_rd_i;
            fifo_data_d[wr_ptr_q] = ld_data_i;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Applied after the clear so a same-edge issue keeps the register busy.
        if (ld_issue_i) begin
            busy_d[ld_issue_rd_i] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        busy_d[0] = 1'b0;
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_rd_q[i]   <= {ADDR_W{1'b0}};
                fifo_data_q[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_q  <= {PTR_W{1'b0}};
            rd_ptr_q  <= {PTR_W{1'b0}};
            count_q   <= {CNT_W{1'b0}};
            busy_q    <= {NREG{1'b0}};
            wr_en_q   <= 1'b0;
            rd_addr_q <= {ADDR_W{1'b0}};
            rd_data_q <= {DATA_W{1'b0}};
            err_q     <= 1'b0;
        end else begin
            fifo_rd_q   <= fifo_rd_d;
            fifo_data_q <= fifo_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            wr_en_q     <= wr_en_d;
            rd_addr_q   <= rd_addr_d;
            rd_data_q   <= rd_data_d;
            err_q       <= err_d;
        end
    end

    assign rs1_busy_o   = busy_q[rs1_addr_i];
    assign rs2_busy_o   = busy_q[rs2_addr_i];
    assign regs_wr_en_o = wr_en_q;
    assign rd_addr_o    = rd_addr_q;
    assign rd_data_o    = rd_data_q;
    assign fifo_count_o = count_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected regfile writes go into a queue that a
// negedge monitor drains; status outputs are checked inline.
module tb_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        alu_valid_i;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_data_i;
    logic        ld_issue_i;
    logic [4:0]  ld_issue_rd_i;
    logic        ld_valid_i;
    logic [4:0]  ld_rd_i;
    logic [31:0] ld_data_i;
    logic        ld_ready_o;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic        rs1_busy_o;
    logic        rs2_busy_o;
    logic        regs_wr_en_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic [1:0]  fifo_count_o;
    logic        err_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [36:0] exp_q[$];

    wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
        .ld_issue_i(ld_issue_i), .ld_issue_rd_i(ld_issue_rd_i),
        .ld_valid_i(ld_valid_i), .ld_rd_i(ld_rd_i), .ld_data_i(ld_data_i),
        .ld_ready_o(ld_ready_o),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
        .regs_wr_en_o(regs_wr_en_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
        .fifo_count_o(fifo_count_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        rst_i = 1'b0; alu_valid_i = 1'b0; alu_rd_i = 5'd0; alu_data_i = 32'd0;
        ld_issue_i = 1'b0; ld_issue_rd_i = 5'd0;
        ld_valid_i = 1'b0; ld_rd_i = 5'd0; ld_data_i = 32'd0;
        rs1_addr_i = 5'd0; rs2_addr_i = 5'd0;
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
        idle();
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] d);
        alu_valid_i = 1'b1; alu_rd_i = rd; alu_data_i = d;
    endtask

    task automatic ld(input logic [4:0] rd, input logic [31:0] d);
        ld_valid_i = 1'b1; ld_rd_i = rd; ld_data_i = d;
    endtask

    task automatic issue(input logic [4:0] rd);
        ld_issue_i = 1'b1; ld_issue_rd_i = rd;
    endtask

    // Every observed write must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (regs_wr_en_o === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got rd=%0d data=%h, expected no write",
                         rd_addr_o, rd_data_o);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({rd_addr_o, rd_data_o} !== e) begin
                    n_bad++;
                    $display("FAIL write_port: got rd=%0d data=%h, expected rd=%0d data=%h",
                             rd_addr_o, rd_data_o, e[36:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        idle();
        rst_i = 1'b1; ld(5'd1, 32'h1);
        repeat (2) begin
            @(posedge clk_i);
            #1;
            @(negedge clk_i);
            chk("rst_ready", 32'(ld_ready_o), 32'd0);
            chk("rst_wr_en", 32'(regs_wr_en_o), 32'd0);
            chk("rst_count", 32'(fifo_count_o), 32'd0);
            chk("rst_err", 32'(err_o), 32'd0);
        end

        // ALU path, one-cycle latency
        cyc(); alu(5'd5, 32'hDEADBEEF); exp_q.push_back({5'd5, 32'hDEADBEEF});
        cyc(); @(negedge clk_i); chk("alu_wr_en_n1", 32'(regs_wr_en_o), 32'd1);
        cyc(); @(negedge clk_i); chk("alu_wr_en_n2", 32'(regs_wr_en_o), 32'd0);

        // Load with scoreboard
        cyc(); issue(5'd7); rs1_addr_i = 5'd7;
        @(negedge clk_i); chk("busy_no_bypass", 32'(rs1_busy_o), 32'd0);
        cyc(); rs1_addr_i = 5'd7;
        @(negedge clk_i); chk("busy7_set", 32'(rs1_busy_o), 32'd1);
        cyc(); ld(5'd7, 32'h1234); rs1_addr_i = 5'd7; exp_q.push_back({5'd7, 32'h1234});
        @(negedge clk_i); chk("ld_ready_empty", 32'(ld_ready_o), 32'd1);
        cyc(); rs1_addr_i = 5'd7;
        @(negedge clk_i);
        chk("ld_no_early_write", 32'(regs_wr_en_o), 32'd0);
        chk("count_one", 32'(fifo_count_o), 32'd1);
        chk("busy7_held", 32'(rs1_busy_o), 32'd1);
        cyc(); rs1_addr_i = 5'd7;
        @(negedge clk_i);
        chk("ld_write_n2", 32'(regs_wr_en_o), 32'd1);
        chk("busy7_clear", 32'(rs1_busy_o), 32'd0);

        // Contention: ALU held four cycles while three loads are offered
        cyc(); issue(5'd10);
        cyc(); issue(5'd11);
        cyc(); issue(5'd12);
        cyc(); alu(5'd20, 32'hA000_0020); ld(5'd10, 32'hB000_0010);
        exp_q.push_back({5'd20, 32'hA000_0020});
        cyc(); alu(5'd21, 32'hA000_0021); ld(5'd11, 32'hB000_0011);
        exp_q.push_back({5'd21, 32'hA000_0021});
        cyc(); alu(5'd22, 32'hA000_0022); ld(5'd12, 32'hB000_0012);
        exp_q.push_back({5'd22, 32'hA000_0022});
        @(negedge clk_i);
        chk("full_ready", 32'(ld_ready_o), 32'd0);
        chk("full_count", 32'(fifo_count_o), 32'd2);
        cyc(); alu(5'd23, 32'hA000_0023); ld(5'd12, 32'hB000_0012);
        exp_q.push_back({5'd23, 32'hA000_0023});
        cyc(); ld(5'd12, 32'hB000_0012);
        exp_q.push_back({5'd10, 32'hB000_0010});
        exp_q.push_back({5'd11, 32'hB000_0011});
        exp_q.push_back({5'd12, 32'hB000_0012});
        @(negedge clk_i); chk("pop_no_push_when_full", 32'(ld_ready_o), 32'd0);
        cyc(); ld(5'd12, 32'hB000_0012);
        @(negedge clk_i); chk("ready_after_pop", 32'(ld_ready_o), 32'd1);
        cyc();
        @(negedge clk_i); chk("pushpop_count", 32'(fifo_count_o), 32'd1);
        cyc();
        @(negedge clk_i);
        chk("drained_count", 32'(fifo_count_o), 32'd0);
        chk("contention_err", 32'(err_o), 32'd0);

        // Same-edge clear and set of busy[3]
        cyc(); issue(5'd3);
        cyc(); ld(5'd3, 32'h0000_0033); exp_q.push_back({5'd3, 32'h0000_0033});
        cyc(); issue(5'd3);
        cyc(); rs1_addr_i = 5'd3;
        @(negedge clk_i);
        chk("busy3_set_wins", 32'(rs1_busy_o), 32'd1);
        chk("setclear_err", 32'(err_o), 32'd0);

        // x0 destination is consumed without a write
        cyc(); alu(5'd0, 32'h0000_0055);
        cyc();
        @(negedge clk_i);
        chk("x0_no_write", 32'(regs_wr_en_o), 32'd0);
        chk("x0_data_updates", rd_data_o, 32'h0000_0055);

        // Double issue raises a sticky error; reset mid-operation clears everything
        cyc(); issue(5'd4);
        cyc(); issue(5'd4);
        cyc(); @(negedge clk_i); chk("err_double_issue", 32'(err_o), 32'd1);
        cyc(); ld(5'd4, 32'h0000_0044);
        cyc(); rst_i = 1'b1;
        @(negedge clk_i);
        chk("err_held", 32'(err_o), 32'd1);
        chk("ready_in_reset", 32'(ld_ready_o), 32'd0);
        cyc(); rs1_addr_i = 5'd3; rs2_addr_i = 5'd4;
        @(negedge clk_i);
        chk("no_write_after_reset", 32'(regs_wr_en_o), 32'd0);
        chk("count_after_reset", 32'(fifo_count_o), 32'd0);
        chk("err_after_reset", 32'(err_o), 32'd0);
        chk("busy3_after_reset", 32'(rs1_busy_o), 32'd0);
        chk("busy4_after_reset", 32'(rs2_busy_o), 32'd0);

        // Load result for a register with no outstanding load
        cyc(); ld(5'd9, 32'h0000_0099); exp_q.push_back({5'd9, 32'h0000_0099});
        cyc(); @(negedge clk_i); chk("err_stray_load", 32'(err_o), 32'd1);
        cyc();
        cyc();
        @(negedge clk_i);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
